// File: rtl/swap_sort_engine.sv
// rtl/swap_sort_engine.sv - block sorter: load DEPTH words, bubble-sort in place, stream out
// One compare-and-swap per cycle; a pass with no swaps ends the sort early.
module swap_sort_engine #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      swap_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_I   = AW'(DEPTH - 2);

  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_p;
  logic [AW-1:0]    r_i;
  logic             r_swapped;
  logic [15:0]      r_swap_count;

  logic             w_in_fire;
  logic             w_out_fire;
  logic [AW-1:0]    w_i1;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_swap;
  logic             w_pass_end;
  logic             w_sort_done;

  assign w_i1        = r_i + 1'b1;
  assign w_a         = r_mem[r_i];
  assign w_b         = r_mem[w_i1];
  assign w_swap      = (r_state == ST_SORT) && (DESCEND ? (w_a < w_b) : (w_a > w_b));
  assign w_pass_end  = (r_i == (LAST_I - r_p));
  // the swap decided this cycle counts toward the early-exit test
  assign w_sort_done = w_pass_end && (!(r_swapped || w_swap) || (r_p == LAST_I));
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;
  assign swap_count  = r_swap_count;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && (r_wr_ptr == LAST_IDX)) w_next = ST_SORT;
      end
      ST_SORT: begin
        if (w_sort_done) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_mem[r_rd_ptr];
        out_last  = (r_rd_ptr == LAST_IDX);
        if (out_ready && (r_rd_ptr == LAST_IDX)) w_next = ST_LOAD;
      end
      default: w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_p          <= '0;
      r_i          <= '0;
      r_swapped    <= 1'b0;
      r_swap_count <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            if (r_wr_ptr == '0) r_swap_count <= '0;
            if (r_wr_ptr == LAST_IDX) begin
              r_wr_ptr  <= '0;
              r_p       <= '0;
              r_i       <= '0;
              r_swapped <= 1'b0;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        ST_SORT: begin
          if (w_swap) begin
            r_swapped <= 1'b1;
            if (r_swap_count != 16'hFFFF) r_swap_count <= r_swap_count + 16'd1;
          end
          if (w_pass_end) begin
            r_i       <= '0;
            r_swapped <= 1'b0;
            if (!w_sort_done) r_p <= r_p + 1'b1;
            else              r_p <= '0;
          end else begin
            r_i <= w_i1;
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (r_rd_ptr == LAST_IDX) begin
              r_rd_ptr <= '0;
              r_wr_ptr <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // storage carries no reset; its contents are meaningless until a block is loaded
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_wr_ptr] <= in_data;
    end else if (w_swap) begin
      r_mem[r_i]  <= w_b;
      r_mem[w_i1] <= w_a;
    end
  end

endmodule

// File: tb/tb_swap_sort_engine.sv
// tb/tb_swap_sort_engine.sv - scoreboard bench for swap_sort_engine
// Ascending and descending instances receive the same blocks; each drains against its own queue.
module tb_swap_sort_engine;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic         a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [W-1:0] a_out_data;
  logic [15:0]  a_swap_count;
  logic         d_in_ready, d_out_valid, d_out_last, d_busy;
  logic [W-1:0] d_out_data;
  logic [15:0]  d_swap_count;

  always #5 clk = ~clk;

  swap_sort_engine #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .busy(a_busy), .swap_count(a_swap_count)
  );

  swap_sort_engine #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b1)) u_dsc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .out_last(d_out_last),
    .busy(d_busy), .swap_count(d_swap_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int ncyc = 0;
  int acc_ncyc = 0;
  int exp_lat = -1;
  int hs_a = 0;
  int hs_d = 0;
  int exp_sw_a = 0;
  int exp_sw_d = 0;
  bit seen_a = 1'b0;
  bit bp_mode = 1'b0;
  int bp_idx = 0;
  bit stall_a = 1'b0;
  bit stall_d = 1'b0;
  logic [W-1:0] hold_a = '0;
  logic [W-1:0] hold_d = '0;
  logic [W:0] qa[$];
  logic [W:0] qd[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic rdy, input logic [W-1:0] data,
                     input logic last);
    logic [W:0] e;
    bit st;
    logic [W-1:0] h;
    int qs;
    string tag;
    st  = (d == 0) ? stall_a : stall_d;
    h   = (d == 0) ? hold_a : hold_d;
    qs  = (d == 0) ? qa.size() : qd.size();
    tag = (d == 0) ? "data_asc" : "data_dsc";
    if (v) begin
      if (st) check("hold_stable", data, h);
      if (qs == 0) begin
        check("unexpected_out", v, 1'b0);
      end else begin
        e = (d == 0) ? qa[0] : qd[0];
        check(tag, data, e[W-1:0]);
        check("out_last", last, e[W]);
        if (rdy) begin
          if (d == 0) begin void'(qa.pop_front()); hs_a++; end
          else        begin void'(qd.pop_front()); hs_d++; end
        end
      end
      st = !rdy;
      h  = data;
    end else begin
      if (st) check("valid_dropped", v, 1'b1);
      st = 1'b0;
    end
    if (d == 0) begin stall_a = st; hold_a = h; end
    else        begin stall_d = st; hold_d = h; end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      if (a_out_valid && !seen_a) begin
        seen_a = 1'b1;
        if (exp_lat > 0) check("first_valid_latency", ncyc - acc_ncyc, exp_lat);
      end
      mon(0, a_out_valid, out_ready, a_out_data, a_out_last);
      mon(1, d_out_valid, out_ready, d_out_data, d_out_last);
    end
  end

  // out_ready pattern 1,0,0,1,0,1 repeating while backpressure is enabled
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      case (bp_idx % 6)
        0, 3, 5: out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      bp_idx++;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic flush();
    qa.delete();
    qd.delete();
    stall_a = 1'b0;
    stall_d = 1'b0;
  endtask

  task automatic chk_reset();
    check("rst_in_ready_a", a_in_ready, 1'b1);
    check("rst_out_valid_a", a_out_valid, 1'b0);
    check("rst_busy_a", a_busy, 1'b0);
    check("rst_swap_count_a", a_swap_count, 16'd0);
    check("rst_out_data_a", a_out_data, '0);
    check("rst_out_last_a", a_out_last, 1'b0);
    check("rst_in_ready_d", d_in_ready, 1'b1);
    check("rst_out_valid_d", d_out_valid, 1'b0);
    check("rst_busy_d", d_busy, 1'b0);
    check("rst_swap_count_d", d_swap_count, 16'd0);
  endtask

  task automatic feed(input logic [W-1:0] blk [D], input int lat);
    logic [W-1:0] s [D];
    logic [W-1:0] t;
    int inv_a, inv_d, tmo;
    inv_a = 0;
    inv_d = 0;
    for (int i = 0; i < D; i++) begin
      s[i] = blk[i];
      for (int j = i + 1; j < D; j++) begin
        if (blk[i] > blk[j]) inv_a++;
        if (blk[i] < blk[j]) inv_d++;
      end
    end
    for (int i = 1; i < D; i++) begin
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    end
    for (int i = 0; i < D; i++) begin
      qa.push_back({(i == D - 1), s[i]});
      qd.push_back({(i == D - 1), s[D-1-i]});
    end
    exp_sw_a = inv_a;
    exp_sw_d = inv_d;
    exp_lat  = lat;
    seen_a   = 1'b0;
    hs_a     = 0;
    hs_d     = 0;
    for (int k = 0; k < D; k++) begin
      tmo = 0;
      @(negedge clk);
      while (!(a_in_ready && d_in_ready) && tmo < 1000) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 1000) check("in_ready_timeout", 1'b0, 1'b1);
      in_valid = 1'b1;
      in_data  = blk[k];
      @(posedge clk);
      #1;
      acc_ncyc = ncyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_block();
    int tmo;
    tmo = 0;
    @(negedge clk);
    while (!(qa.size() == 0 && qd.size() == 0 && a_in_ready && d_in_ready) && tmo < 2000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 2000) check("drain_timeout", 1'b0, 1'b1);
    check("swap_count_asc", a_swap_count, exp_sw_a);
    check("swap_count_dsc", d_swap_count, exp_sw_d);
    check("handshakes_asc", hs_a, D);
    check("handshakes_dsc", hs_d, D);
    check("busy_idle", a_busy | d_busy, 1'b0);
  endtask

  logic [W-1:0] b [D];
  int tmo_main;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    b = '{8, 7, 6, 5, 4, 3, 2, 1};
    feed(b, 29);
    finish_block();
    check("reversed_swaps_const", a_swap_count, 16'd28);

    b = '{1, 2, 3, 4, 5, 6, 7, 8};
    feed(b, 8);
    finish_block();
    check("sorted_swaps_const", a_swap_count, 16'd0);

    b = '{566, 254, 826, 799, 110, 221, 254, 426};
    feed(b, -1);
    finish_block();

    bp_idx  = 0;
    bp_mode = 1'b1;
    for (int i = 0; i < D; i++) b[i] = $urandom_range(0, 1000);
    feed(b, -1);
    finish_block();
    bp_mode = 1'b0;

    b = '{100, 426, 545, 369, 0, 1, 2, 3};
    feed(b, -1);
    finish_block();

    // reset pulsed after two output handshakes
    b = '{40, 10, 30, 20, 80, 60, 70, 50};
    feed(b, -1);
    tmo_main = 0;
    while (hs_a < 2 && tmo_main < 500) begin
      @(posedge clk);
      tmo_main++;
    end
    if (tmo_main >= 500) check("drain_start_timeout", 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    flush();
    @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // reset sampled at the fifth edge after the last accept, mid-sort
    b = '{5, 8, 1, 7, 3, 6, 2, 4};
    feed(b, -1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    flush();
    @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    b = '{2, 1, 8, 7, 6, 5, 4, 3};
    feed(b, -1);
    finish_block();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
